multicycle_computer_controller_flag_register: RTL and testbench

MULTICYCLE_COMPUTER_CONTROLLER_FLAG_REGISTER -- requirements
Module: multicycle_computer_controller_flag_register

---
 rtl/multicycle_computer_controller_flag_register_pkg.sv | 28 ++
 rtl/multicycle_computer_flag_gen.sv | 29 ++
 rtl/multicycle_computer_controller_flag_register.sv | 74 +++++++
 tb/tb_multicycle_computer_controller_flag_register.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/multicycle_computer_controller_flag_register_pkg.sv
// Shared encodings for the flag register: ALU ops, NZCV bit positions, FSM states.
// The condition-check block indexes FLAGS with the same *_IDX constants.
package multicycle_computer_controller_flag_register_pkg;

    localparam int unsigned NZCV_W = 4;
    localparam int unsigned N_IDX  = 3;
    localparam int unsigned Z_IDX  = 2;
    localparam int unsigned C_IDX  = 1;
    localparam int unsigned V_IDX  = 0;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_ctrl_e;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } flag_state_e;

    // Logical ops take C from the shifter and preserve V.
    function automatic logic is_logical(input alu_ctrl_e op);
        return (op == ALU_AND) || (op == ALU_ORR);
    endfunction

endpackage

// File: rtl/multicycle_computer_flag_gen.sv
// Combinational NZCV generation from the execute-cycle ALU/shifter outputs.
module multicycle_computer_flag_gen
    import multicycle_computer_controller_flag_register_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_carry,
    input  logic              alu_overflow,
    input  logic              shifter_carry,
    input  alu_ctrl_e         alu_control,
    input  logic              cur_v,
    output logic [NZCV_W-1:0] nzcv_c
);

    always_comb begin
        nzcv_c        = '0;
        nzcv_c[N_IDX] = alu_result[WIDTH-1];
        nzcv_c[Z_IDX] = (alu_result == '0);
        if (is_logical(alu_control)) begin
            nzcv_c[C_IDX] = shifter_carry;
            nzcv_c[V_IDX] = cur_v;
        end else begin
            nzcv_c[C_IDX] = alu_carry;
            nzcv_c[V_IDX] = alu_overflow;
        end
    end

endmodule

// File: rtl/multicycle_computer_controller_flag_register.sv
// Two-phase NZCV register: captures pending flags in execute, commits them in writeback.
module multicycle_computer_controller_flag_register
    import multicycle_computer_controller_flag_register_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic              alu_carry,
    input  logic              alu_overflow,
    input  logic              shifter_carry,
    input  logic [1:0]        alu_control,
    input  logic              set_flags,
    input  logic              cond_pass,
    input  logic              capture,
    input  logic              commit,
    input  logic              abort,
    output logic [NZCV_W-1:0] flags,
    output logic              pending,
    output logic              overwrite
);

    flag_state_e       state;
    logic [NZCV_W-1:0] pend_nzcv;
    logic              pend_we;
    logic [NZCV_W-1:0] new_nzcv_c;

    multicycle_computer_flag_gen #(
        .WIDTH (WIDTH)
    ) u_flag_gen (
        .alu_result    (alu_result),
        .alu_carry     (alu_carry),
        .alu_overflow  (alu_overflow),
        .shifter_carry (shifter_carry),
        .alu_control   (alu_ctrl_e'(alu_control)),
        .cur_v         (flags[V_IDX]),
        .nzcv_c        (new_nzcv_c)
    );

    // A simultaneous capture+commit retires the old pending value before latching the new one.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            flags     <= '0;
            pend_nzcv <= '0;
            pend_we   <= 1'b0;
            overwrite <= 1'b0;
        end else begin
            overwrite <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                pend_nzcv <= '0;
                pend_we   <= 1'b0;
            end else begin
                if (commit && (state == HOLD) && pend_we) begin
                    flags <= pend_nzcv;
                end
                if (capture) begin
                    pend_nzcv <= new_nzcv_c;
                    pend_we   <= set_flags & cond_pass;
                    state     <= HOLD;
                    overwrite <= (state == HOLD) && !commit;
                end else if (commit && (state == HOLD)) begin
                    state   <= IDLE;
                    pend_we <= 1'b0;
                end
            end
        end
    end

    assign pending = (state == HOLD);

endmodule

// File: tb/tb_multicycle_computer_controller_flag_register.sv
// Directed bench for the flag register; expectations go through a scoreboard queue.
module tb_multicycle_computer_controller_flag_register;

    localparam int unsigned WIDTH = 32;

    typedef struct {
        string      tag;
        logic [3:0] flags;
        logic       pending;
        logic       overwrite;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;
    logic             alu_overflow;
    logic             shifter_carry;
    logic [1:0]       alu_control;
    logic             set_flags;
    logic             cond_pass;
    logic             capture;
    logic             commit;
    logic             abort;
    logic [3:0]       flags;
    logic             pending;
    logic             overwrite;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    multicycle_computer_controller_flag_register #(
        .WIDTH (WIDTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .alu_result    (alu_result),
        .alu_carry     (alu_carry),
        .alu_overflow  (alu_overflow),
        .shifter_carry (shifter_carry),
        .alu_control   (alu_control),
        .set_flags     (set_flags),
        .cond_pass     (cond_pass),
        .capture       (capture),
        .commit        (commit),
        .abort         (abort),
        .flags         (flags),
        .pending       (pending),
        .overwrite     (overwrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, push the expected post-edge state, then pop and compare.
    task automatic step(input string tag,
                        input logic rst, input logic cap, input logic com, input logic abt,
                        input logic [1:0] ctl, input logic [WIDTH-1:0] res,
                        input logic ac, input logic ao, input logic sc,
                        input logic sf, input logic cp,
                        input logic [3:0] e_flags, input logic e_pend, input logic e_ovw);
        exp_t e;
        reset         = rst;
        capture       = cap;
        commit        = com;
        abort         = abt;
        alu_control   = ctl;
        alu_result    = res;
        alu_carry     = ac;
        alu_overflow  = ao;
        shifter_carry = sc;
        set_flags     = sf;
        cond_pass     = cp;
        sb_q.push_back('{tag, e_flags, e_pend, e_ovw});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        checks++;
        assert (flags === e.flags) else begin
            errors++;
            $error("FAIL %s flags: got %b want %b", e.tag, flags, e.flags);
        end
        checks++;
        assert (pending === e.pending) else begin
            errors++;
            $error("FAIL %s pending: got %b want %b", e.tag, pending, e.pending);
        end
        checks++;
        assert (overwrite === e.overwrite) else begin
            errors++;
            $error("FAIL %s overwrite: got %b want %b", e.tag, overwrite, e.overwrite);
        end
    endtask

    initial begin
        //    tag            rst cap com abt ctl    result        ac   ao   sc   sf   cp   flags   pnd  ovw
        step("reset",       1, 0, 0, 0, 2'b00, 32'h0000_0000, 0, 0, 0, 0, 0, 4'b0000, 0, 0);
        step("idle",        0, 0, 0, 0, 2'b00, 32'h0000_0000, 0, 0, 0, 0, 0, 4'b0000, 0, 0);

        // ADD producing zero with carry
        step("add_cap",     0, 1, 0, 0, 2'b00, 32'h0000_0000, 1, 0, 0, 1, 1, 4'b0000, 1, 0);
        step("add_com",     0, 0, 1, 0, 2'b00, 32'h1234_5678, 0, 1, 1, 0, 0, 4'b0110, 0, 0);

        // SUB: negative, borrow, overflow
        step("sub_cap",     0, 1, 0, 0, 2'b01, 32'h8000_0000, 0, 1, 1, 1, 1, 4'b0110, 1, 0);
        step("sub_com",     0, 0, 1, 0, 2'b01, 32'h0000_0000, 1, 0, 0, 0, 0, 4'b1001, 0, 0);

        // Set V=1 via ADD, then AND keeps V and takes the shifter carry
        step("pre_cap",     0, 1, 0, 0, 2'b00, 32'h0000_0001, 0, 1, 0, 1, 1, 4'b1001, 1, 0);
        step("pre_com",     0, 0, 1, 0, 2'b00, 32'h0000_0000, 0, 0, 0, 0, 0, 4'b0001, 0, 0);
        step("and_cap",     0, 1, 0, 0, 2'b10, 32'h0000_0005, 0, 0, 1, 1, 1, 4'b0001, 1, 0);
        step("and_com",     0, 0, 1, 0, 2'b10, 32'h0000_0000, 1, 1, 0, 0, 0, 4'b0011, 0, 0);

        // Gating by cond_pass and set_flags
        step("nocond_cap",  0, 1, 0, 0, 2'b00, 32'h0000_0000, 1, 0, 0, 1, 0, 4'b0011, 1, 0);
        step("nocond_com",  0, 0, 1, 0, 2'b00, 32'h0000_0000, 1, 0, 0, 0, 0, 4'b0011, 0, 0);
        step("nos_cap",     0, 1, 0, 0, 2'b00, 32'h8000_0000, 1, 1, 0, 0, 1, 4'b0011, 1, 0);
        step("nos_com",     0, 0, 1, 0, 2'b00, 32'h0000_0000, 0, 0, 0, 0, 0, 4'b0011, 0, 0);

        // Commit in IDLE ignored
        step("idle_com",    0, 0, 1, 0, 2'b00, 32'h0000_0000, 1, 1, 1, 1, 1, 4'b0011, 0, 0);

        // Overlap: second capture replaces the first, pulsing overwrite once
        step("ovl_cap1",    0, 1, 0, 0, 2'b00, 32'h0000_0000, 1, 0, 0, 1, 1, 4'b0011, 1, 0);
        step("ovl_cap2",    0, 1, 0, 0, 2'b00, 32'hFFFF_FFFF, 0, 0, 0, 1, 1, 4'b0011, 1, 1);
        step("ovl_wait",    0, 0, 0, 0, 2'b00, 32'h0000_0000, 1, 1, 1, 1, 1, 4'b0011, 1, 0);
        step("ovl_com",     0, 0, 1, 0, 2'b00, 32'h0000_0000, 1, 1, 1, 1, 1, 4'b1000, 0, 0);

        // ORR with V sampled from flags at capture (V=0 here)
        step("orr_cap",     0, 1, 0, 0, 2'b11, 32'h0000_0000, 0, 1, 1, 1, 1, 4'b1000, 1, 0);
        step("orr_com",     0, 0, 1, 0, 2'b11, 32'h0000_0000, 0, 1, 0, 1, 1, 4'b0110, 0, 0);

        // Capture+commit together: old value retires, new one stays pending
        step("cc_cap",      0, 1, 0, 0, 2'b00, 32'h0000_0000, 1, 0, 0, 1, 1, 4'b0110, 1, 0);
        step("cc_both",     0, 1, 1, 0, 2'b01, 32'h8000_0000, 0, 1, 0, 1, 1, 4'b0110, 1, 0);
        step("cc_com",      0, 0, 1, 0, 2'b00, 32'h0000_0000, 0, 0, 0, 0, 0, 4'b1001, 0, 0);

        // Abort beats commit and capture
        step("ab_cap",      0, 1, 0, 0, 2'b00, 32'h0000_0000, 1, 0, 0, 1, 1, 4'b1001, 1, 0);
        step("ab_com",      0, 0, 1, 1, 2'b00, 32'h0000_0000, 1, 0, 0, 1, 1, 4'b1001, 0, 0);
        step("ab_cap2",     0, 1, 0, 1, 2'b00, 32'h0000_0000, 1, 0, 0, 1, 1, 4'b1001, 0, 0);
        step("ab_after",    0, 0, 1, 0, 2'b00, 32'h0000_0000, 1, 0, 0, 1, 1, 4'b1001, 0, 0);

        // Reset mid-HOLD with commit: no commit, everything cleared
        step("rst_cap",     0, 1, 0, 0, 2'b00, 32'h0000_0000, 1, 1, 0, 1, 1, 4'b1001, 1, 0);
        step("rst_com",     1, 0, 1, 0, 2'b00, 32'h0000_0000, 1, 1, 0, 1, 1, 4'b0000, 0, 0);
        step("rst_after",   0, 0, 1, 0, 2'b00, 32'h0000_0000, 1, 1, 0, 1, 1, 4'b0000, 0, 0);

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: got %0d entries want 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
